// File: rtl/cavlc_level_encode.sv
// rtl/cavlc_level_encode.sv - CAVLC trailing-ones/level codeword encoder with 16-bit MSB-first word packer
`timescale 1ns/1ps
module cavlc_level_encode #(
    parameter int WORD_W  = 16,
    parameter int LEVEL_W = 13
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Start,
    input  logic [4:0]         TotalCoeff,
    input  logic [1:0]         TrailingOnes,
    input  logic [LEVEL_W-1:0] LevelIn,
    input  logic               LevelValid,
    output logic               LevelReady,
    input  logic               Flush,
    output logic [WORD_W-1:0]  WordOut,
    output logic               WrReq,
    input  logic               FifoFull,
    output logic               BlockDone,
    output logic               LevelErr,
    output logic               Busy
);

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [43:0] acc_q, acc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  sl_q, sl_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  total_q, total_d;
    logic [1:0]  t1_q, t1_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        lvl_neg;
    logic [13:0] lvl_abs;
    logic [14:0] lvl_code_raw;
    logic [14:0] lvl_code;
    logic        is_t1;
    logic        first_adj;
    logic [14:0] esc_base;
    logic [14:0] esc_sub;
    logic [3:0]  prefix;
    logic [11:0] suf;
    logic [3:0]  suf_len;
    logic        clamp;
    logic [27:0] cw_val;
    logic [4:0]  cw_len;
    logic [5:0]  app_shift;
    logic [2:0]  sl_base;
    logic [13:0] sl_thr;
    logic [2:0]  sl_next;
    logic        level_acc;

    assign lvl_neg      = LevelIn[LEVEL_W-1];
    assign lvl_abs      = lvl_neg ? (~{LevelIn[LEVEL_W-1], LevelIn} + 14'd1) : {LevelIn[LEVEL_W-1], LevelIn};
    assign lvl_code_raw = lvl_neg ? ({lvl_abs, 1'b0} - 15'd1) : ({lvl_abs, 1'b0} - 15'd2);
    assign is_t1        = idx_q < {3'b000, t1_q};
    // The first non-trailing-one level cannot be +/-1 unless three trailing ones were coded.
    assign first_adj    = (idx_q == {3'b000, t1_q}) && (t1_q != 2'd3);
    assign lvl_code     = first_adj ? (lvl_code_raw - 15'd2) : lvl_code_raw;
    assign esc_base     = (sl_q == 3'd0) ? 15'd30 : (15'd15 << sl_q);
    assign esc_sub      = lvl_code - esc_base;

    always_comb begin
        prefix  = 4'd0;
        suf     = 12'd0;
        suf_len = 4'd0;
        clamp   = 1'b0;
        if (sl_q == 3'd0 && lvl_code < 15'd14) begin
            prefix = lvl_code[3:0];
        end else if (sl_q == 3'd0 && lvl_code < 15'd30) begin
            prefix  = 4'd14;
            suf     = 12'(lvl_code - 15'd14);
            suf_len = 4'd4;
        end else if (sl_q != 3'd0 && lvl_code < esc_base) begin
            prefix  = 4'(lvl_code >> sl_q);
            suf     = 12'(lvl_code & ~(15'h7FFF << sl_q));
            suf_len = {1'b0, sl_q};
        end else begin
            prefix  = 4'd15;
            suf_len = 4'd12;
            if (esc_sub > 15'd4095) begin
                clamp = 1'b1;
                suf   = 12'hFFF;
            end else begin
                suf = esc_sub[11:0];
            end
        end
    end

    always_comb begin
        cw_val = 28'd0;
        cw_len = 5'd0;
        if (is_t1) begin
            cw_val = {27'd0, lvl_neg};
            cw_len = 5'd1;
        end else begin
            cw_val = {16'd0, suf} | (28'd1 << suf_len);
            cw_len = {1'b0, prefix} + 5'd1 + {1'b0, suf_len};
        end
    end

    // Leading prefix zeros are implicit: the codeword is right-aligned and placed so its end lands at BitCount+len.
    assign app_shift = 6'd44 - bit_cnt_q - {1'b0, cw_len};

    assign sl_base = (sl_q == 3'd0) ? 3'd1 : sl_q;
    assign sl_thr  = 14'd3 << (sl_base - 3'd1);
    assign sl_next = ((lvl_abs > sl_thr) && (sl_base < 3'd6)) ? sl_base + 3'd1 : sl_base;

    assign LevelReady = (state_q == S_ENCODE) && (bit_cnt_q < 6'd16);
    assign level_acc  = LevelReady && LevelValid;
    assign WrReq      = !FifoFull && ((bit_cnt_q >= 6'd16) || (state_q == S_FLUSH));
    assign WordOut    = WrReq ? acc_q[43:28] : '0;
    assign BlockDone  = done_q;
    assign LevelErr   = err_q;
    assign Busy       = state_q != S_IDLE;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        sl_d      = sl_q;
        idx_d     = idx_q;
        total_d   = total_q;
        t1_d      = t1_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // Bits below BitCount are always zero, so a plain shift also pads the flushed word.
        if (WrReq) begin
            acc_d     = acc_q << 16;
            bit_cnt_d = (bit_cnt_q > 6'd16) ? (bit_cnt_q - 6'd16) : 6'd0;
        end
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    total_d = TotalCoeff;
                    t1_d    = TrailingOnes;
                    idx_d   = 5'd0;
                    sl_d    = ((TotalCoeff > 5'd10) && (TrailingOnes < 2'd3)) ? 3'd1 : 3'd0;
                    if (TotalCoeff == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ENCODE;
                    end
                end else if (Flush && (bit_cnt_d != 6'd0)) begin
                    state_d = S_FLUSH;
                end
            end
            S_ENCODE: begin
                if (level_acc) begin
                    acc_d     = acc_q | ({16'd0, cw_val} << app_shift);
                    bit_cnt_d = bit_cnt_q + {1'b0, cw_len};
                    idx_d     = idx_q + 5'd1;
                    if (!is_t1) begin
                        sl_d  = sl_next;
                        err_d = clamp;
                    end
                    if (idx_q == total_q - 5'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (WrReq && (bit_cnt_q <= 6'd16)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            sl_q      <= '0;
            idx_q     <= '0;
            total_q   <= '0;
            t1_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            sl_q      <= sl_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            t1_q      <= t1_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cavlc_level_encode.sv
// tb/tb_cavlc_level_encode.sv - scoreboard bench for cavlc_level_encode with hand-derived codewords
`timescale 1ns/1ps
module tb_cavlc_level_encode;

    logic               Clk = 1'b0;
    logic               nReset;
    logic               Start;
    logic [4:0]         TotalCoeff;
    logic [1:0]         TrailingOnes;
    logic [12:0]        LevelIn;
    logic               LevelValid;
    logic               LevelReady;
    logic               Flush;
    logic [15:0]        WordOut;
    logic               WrReq;
    logic               FifoFull;
    logic               BlockDone;
    logic               LevelErr;
    logic               Busy;

    cavlc_level_encode dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .TotalCoeff(TotalCoeff),
        .TrailingOnes(TrailingOnes), .LevelIn(LevelIn), .LevelValid(LevelValid),
        .LevelReady(LevelReady), .Flush(Flush), .WordOut(WordOut), .WrReq(WrReq),
        .FifoFull(FifoFull), .BlockDone(BlockDone), .LevelErr(LevelErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          wr_cnt = 0;
    int          n_acc = 0;
    logic [15:0] exp_q[$];
    bit          bitq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected word whenever the DUT writes one.
    always @(negedge Clk) begin
        if (nReset) begin
            if (BlockDone) done_cnt++;
            if (LevelErr) err_cnt++;
            if (WrReq) begin
                wr_cnt++;
                check("wrreq_while_full", {31'd0, FifoFull}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%04h expected no write", WordOut);
                end else begin
                    check("word", {16'd0, WordOut}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic drain_words();
        logic [15:0] w;
        while (bitq.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[15-i] = bitq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic push_bit(input bit b);
        bitq.push_back(b);
        drain_words();
    endtask

    task automatic push_code(input int pfx, input int sfx, input int slen);
        logic [11:0] s;
        s = 12'(sfx);
        for (int i = 0; i < pfx; i++) bitq.push_back(1'b0);
        bitq.push_back(1'b1);
        for (int i = slen - 1; i >= 0; i--) bitq.push_back(s[i]);
        drain_words();
    endtask

    task automatic push_flush();
        while (bitq.size() % 16 != 0) bitq.push_back(1'b0);
        drain_words();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (!Busy) begin
                tick(1);
                return;
            end
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic start_block(input int tc, input int to, input bit with_flush);
        Start = 1'b1;
        TotalCoeff = 5'(tc);
        TrailingOnes = 2'(to);
        Flush = with_flush;
        tick(1);
        Start = 1'b0;
        Flush = 1'b0;
    endtask

    task automatic send_level(input int l);
        LevelIn = 13'(l);
        LevelValid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (LevelReady) begin
                tick(1);
                LevelValid = 1'b0;
                n_acc++;
                return;
            end
        end
        LevelValid = 1'b0;
        check("level_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_flush();
        wait_idle();
        push_flush();
        Flush = 1'b1;
        tick(1);
        Flush = 1'b0;
        wait_idle();
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrreq"}, {31'd0, WrReq}, 32'd0);
        check({tag, "_levelready"}, {31'd0, LevelReady}, 32'd0);
        check({tag, "_blockdone"}, {31'd0, BlockDone}, 32'd0);
        check({tag, "_levelerr"}, {31'd0, LevelErr}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_wordout"}, {16'd0, WordOut}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int wr0;
        int acc0;
        nReset = 1'b0; Start = 1'b0; TotalCoeff = '0; TrailingOnes = '0;
        LevelIn = '0; LevelValid = 1'b0; Flush = 1'b0; FifoFull = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        nReset = 1'b1;
        tick(2);

        // TC=1 TO=0 +2: codeword "1"
        start_block(1, 0, 1'b0);
        push_code(0, 0, 0);
        send_level(2);
        tick(2);
        check("t1_blockdone", done_cnt, 1);
        check("t1_levelready_low", {31'd0, LevelReady}, 32'd0);
        do_flush();
        check("t1_words", wr_cnt, 1);

        // TC=2 TO=1 -1,+3: "1","001"
        start_block(2, 1, 1'b0);
        push_bit(1'b1);
        push_code(2, 0, 0);
        send_level(-1);
        send_level(3);
        do_flush();
        check("t2_blockdone", done_cnt, 2);
        check("t2_words", wr_cnt, 2);

        // TC=4 TO=3 +1,+1,+1,+8: 3 sign bits then prefix 14, suffix 0000
        start_block(4, 3, 1'b0);
        push_bit(1'b0); push_bit(1'b0); push_bit(1'b0);
        push_code(14, 0, 4);
        send_level(1); send_level(1); send_level(1); send_level(8);
        tick(3);
        check("t3_first_word", wr_cnt, 3);
        do_flush();
        check("t3_words", wr_cnt, 4);

        // TC=11 TO=0 eleven x +1000, all escapes with growing suffixLength
        wr0 = wr_cnt;
        acc0 = n_acc;
        start_block(11, 0, 1'b0);
        push_code(15, 1966, 12);
        push_code(15, 1938, 12);
        push_code(15, 1878, 12);
        push_code(15, 1758, 12);
        push_code(15, 1518, 12);
        for (int k = 0; k < 6; k++) push_code(15, 1038, 12);
        FifoFull = 1'b1;
        fork
            begin
                for (int k = 0; k < 11; k++) send_level(1000);
            end
            begin
                tick(20);
                check("t4_stalled_accepts", n_acc - acc0, 1);
                check("t4_levelready_stall", {31'd0, LevelReady}, 32'd0);
                check("t4_no_write_full", wr_cnt - wr0, 0);
                FifoFull = 1'b0;
            end
        join
        do_flush();
        check("t4_words", wr_cnt - wr0, 20);
        check("t4_levelerr", err_cnt, 0);
        check("t4_blockdone", done_cnt, 4);

        // Escape clamp: -4096 -> prefix 15, suffix 4095
        start_block(1, 0, 1'b0);
        push_code(15, 4095, 12);
        send_level(-4096);
        tick(3);
        check("t5_levelerr", err_cnt, 1);
        do_flush();
        check("t5_blockdone", done_cnt, 5);

        // TC=0: BlockDone only
        wr0 = wr_cnt;
        start_block(0, 0, 1'b0);
        tick(2);
        check("t6_tc0_blockdone", done_cnt, 6);
        check("t6_tc0_busy", {31'd0, Busy}, 32'd0);

        // Start+Flush together with bits pending: Flush dropped
        start_block(1, 0, 1'b0);
        push_code(0, 0, 0);
        send_level(2);
        wait_idle();
        start_block(0, 0, 1'b1);
        check("t6_flush_dropped_busy", {31'd0, Busy}, 32'd0);
        tick(3);
        check("t6_flush_dropped_words", wr_cnt - wr0, 0);
        check("t6_blockdone", done_cnt, 8);
        do_flush();
        check("t6_flush_word", wr_cnt - wr0, 1);

        // Reset mid-block: partial bits discarded
        wr0 = wr_cnt;
        start_block(3, 0, 1'b0);
        send_level(5);
        tick(1);
        nReset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        tick(2);
        nReset = 1'b1;
        tick(1);
        Flush = 1'b1;
        tick(1);
        Flush = 1'b0;
        check("midreset_flush_ignored", {31'd0, Busy}, 32'd0);
        tick(4);
        check("midreset_no_word", wr_cnt - wr0, 0);
        check("midreset_blockdone", done_cnt, 8);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
